// File: rtl/pattern_serializer_pkg.sv
// Shared constants and state encoding for the pattern serializer and its
// sequence-detector consumer.
package pattern_serializer_pkg;

   localparam int unsigned SerWidth       = 8;
   localparam int unsigned SerLenW        = 4;
   localparam int unsigned DefaultTickDiv = 25000000;

   typedef enum logic [1:0] {
      StIdle  = 2'b00,
      StShift = 2'b01,
      StDone  = 2'b10
   } state_e;

endpackage

// File: rtl/pattern_serializer_tick_divider.sv
// Loadable down-counter; tc_o flags a count of zero. Also used for display blinking.
module tick_divider #(
   parameter int unsigned Width = 25
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clr_i,
   input  logic             load_i,
   input  logic [Width-1:0] load_val_i,
   input  logic             en_i,
   output logic [Width-1:0] count_o,
   output logic             tc_o
);

   logic [Width-1:0] count_d, count_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   // Clear beats load beats decrement; the counter parks at zero.
   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = '0;
      end else if (load_i) begin
         count_d = load_val_i;
      end else if (en_i && (count_q != '0)) begin
         count_d = count_q - Width'(1);
      end
   end

   assign count_o = count_q;
   assign tc_o    = (count_q == '0);

endmodule

// File: rtl/pattern_serializer.sv
// Replays a latched parallel pattern MSB-first on serial_out_o, one bit per
// TICK_DIV clocks, with a bit_valid_o strobe in the last cycle of each bit.
module pattern_serializer
   import pattern_serializer_pkg::*;
#(
   parameter int unsigned WIDTH    = SerWidth,
   parameter int unsigned LEN_W    = SerLenW,
   parameter int unsigned TICK_DIV = DefaultTickDiv
) (
   input  logic             clock_i,
   input  logic             resetn_i,
   input  logic             start_i,
   input  logic             abort_i,
   input  logic [WIDTH-1:0] pattern_i,
   input  logic [LEN_W-1:0] length_i,
   output logic             serial_out_o,
   output logic             bit_valid_o,
   output logic             busy_o,
   output logic             done_o
);

   localparam int unsigned      DivW      = $clog2(TICK_DIV);
   localparam logic [DivW-1:0]  DivReload = DivW'(TICK_DIV - 1);
   localparam logic [LEN_W-1:0] MaxLen    = LEN_W'(WIDTH);

   state_e            state_d, state_q;
   logic [WIDTH-1:0]  sreg_d, sreg_q;
   logic [LEN_W-1:0]  cnt_d, cnt_q;
   logic [LEN_W-1:0]  len_eff, shamt;
   logic              div_clr, div_load, div_en, div_tc;
   logic [DivW-1:0]   div_count;

   tick_divider #(
      .Width (DivW)
   ) u_tick_divider (
      .clk_i      (clock_i),
      .rst_ni     (resetn_i),
      .clr_i      (div_clr),
      .load_i     (div_load),
      .load_val_i (DivReload),
      .en_i       (div_en),
      .count_o    (div_count),
      .tc_o       (div_tc)
   );

   // Left-align the pattern so the first bit to send always sits at the MSB.
   assign len_eff = (length_i > MaxLen) ? MaxLen : length_i;
   assign shamt   = MaxLen - len_eff;

   always_ff @(posedge clock_i or negedge resetn_i) begin
      if (!resetn_i) begin
         state_q <= StIdle;
         sreg_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         sreg_q  <= sreg_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      sreg_d   = sreg_q;
      cnt_d    = cnt_q;
      div_clr  = 1'b0;
      div_load = 1'b0;
      div_en   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start_i && !abort_i && (length_i != '0)) begin
               sreg_d   = pattern_i << shamt;
               cnt_d    = len_eff;
               div_load = 1'b1;
               state_d  = StShift;
            end
         end
         StShift: begin
            if (abort_i) begin
               state_d = StIdle;
               sreg_d  = '0;
               cnt_d   = '0;
               div_clr = 1'b1;
            end else if (div_tc) begin
               if (cnt_q > LEN_W'(1)) begin
                  sreg_d   = sreg_q << 1;
                  cnt_d    = cnt_q - LEN_W'(1);
                  div_load = 1'b1;
               end else begin
                  state_d = StDone;
                  sreg_d  = '0;
                  cnt_d   = '0;
                  div_clr = 1'b1;
               end
            end else begin
               div_en = 1'b1;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
            sreg_d  = '0;
            cnt_d   = '0;
            div_clr = 1'b1;
         end
      endcase
   end

   // Outputs decode registers only, so reset clears them without a clock edge.
   assign busy_o       = (state_q == StShift);
   assign done_o       = (state_q == StDone);
   assign serial_out_o = busy_o & sreg_q[WIDTH-1];
   assign bit_valid_o  = busy_o & div_tc;

   logic unused_div_count;
   assign unused_div_count = ^div_count;

endmodule
